buffer_writer: RTL and testbench
================================

BUFFER_WRITER -- requirements
Module: buffer_writer

Interface
REQ-001 Parameter PX_PER_BUF, default 640, pixels per ping-pong buffer (one display line); legal range 2..1023.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 CSHost  input  1  host chip select; writer accepts bytes only while high.
REQ-005 HostData  input  8  colour byte from host; pixel order R, G, B.
REQ-006 HostValid  input  1  HostData valid.
REQ-007 HostReady  output  1  writer can accept HostData this cycle.
REQ-008 Buf0Empty, Buf1Empty  input  1 each  one-cycle pulse from display statemachine: buffer fully read out.
REQ-009 WE0, WE1  output  1 each  write strobe into buffer 0 / buffer 1.
REQ-010 SelR, SelG, SelB  output  1 each  one-hot colour-plane select, valid with WE0/WE1.
REQ-011 WrData  output  8  byte written with WE0/WE1.
REQ-012 IncAddr0, ResetAddr0, IncAddr1, ResetAddr1  output  1 each  control of the external buffer address counters.
REQ-013 Buf0Full, Buf1Full  output  1 each  level: buffer holds a complete line not yet drained.
REQ-014 WrPx  output  10  pixel index currently being written in the target buffer.

Function
REQ-015 States: INIT, IDLE, WRITE, WAIT_BUF, SWITCH; all outputs registered.
REQ-016 INIT: entered on reset; lasts one cycle; drives ResetAddr0=ResetAddr1=1; then IDLE.
REQ-017 IDLE -> WRITE when CSHost=1 and target buffer not full; IDLE -> WAIT_BUF when CSHost=1 and target full.
REQ-018 HostReady=1 only in WRITE with CSHost=1; transfer occurs on the cycle HostValid=1 and HostReady=1.
REQ-019 Each transfer: next cycle WE of the target buffer=1, WrData=captured byte, Sel one-hot by byte phase (R->SelR, G->SelG, B->SelB); latency 1 cycle.
REQ-020 Byte phase advances R->G->B->R per transfer only; unchanged on idle cycles.
REQ-021 On the B byte, IncAddr of the target buffer pulses in the same cycle as its WE; WrPx increments.
REQ-022 When the B byte of pixel PX_PER_BUF-1 is written: target Full flag sets, WrPx returns to 0, state -> SWITCH.
REQ-023 SWITCH: one cycle; ResetAddr of the just-filled buffer=1; target toggles; then WRITE if new target not full, else WAIT_BUF.
REQ-024 WAIT_BUF: HostReady=0; -> WRITE the cycle after target Full clears.
REQ-025 Full flag clears on its Empty pulse; Empty pulse while Full=0 is ignored.
REQ-026 Same-cycle set and Empty pulse on one buffer: set wins, flag stays 1.
REQ-027 CSHost falling in WRITE: HostReady=0 that cycle, state -> IDLE; byte phase, WrPx, target retained; resume on CSHost high.
REQ-028 HostValid with HostReady=0: no write, no state change; host holds data.
REQ-029 WE0 and WE1 never both 1; at most one Sel high; all Sel low when no WE.

Reset
REQ-030 Reset (synchronous, any state, mid-pixel included) -> next cycle: state INIT, target buffer 0, phase R, WrPx=0, Buf0Full=Buf1Full=0, HostReady=0, WE0=WE1=0, Sel*=0, WrData=0, IncAddr*=0.
REQ-031 ResetAddr0=ResetAddr1=1 in the INIT cycle, 0 otherwise except per REQ-023.

Verification (PX_PER_BUF=4)
REQ-032 Reset, CSHost=1, 12 bytes 0x01..0x0C back-to-back -> WE0 12 cycles, Sel R,G,B repeating, IncAddr0 on 0x03,0x06,0x09,0x0C, Buf0Full=1, ResetAddr0 pulse, then writes to WE1.
REQ-033 Fill both buffers, continue HostValid=1 -> HostReady=0 in WAIT_BUF; Buf0Empty pulse -> Buf0Full=0, writing resumes on WE0 two cycles later.
REQ-034 Drop CSHost after a G byte for 5 cycles -> no WE; on return next byte written with SelB, IncAddr pulses.
REQ-035 Buf1Empty pulse in same cycle Buf1Full sets -> Buf1Full stays 1.
REQ-036 Assert reset after 7 bytes -> Buf0Full=0, WrPx=0, ResetAddr0/1 pulse; next byte written to buffer 0 with SelR.
REQ-037 Throughout all scenarios: assert WE0&WE1 never both 1 and Sel one-hot whenever WE active.

Source files
------------

// File: rtl/buffer_writer.sv
//------------------------------------------------------------------------------
// Module      : buffer_writer
// Description : Accepts RGB host bytes and writes them into two ping-pong line
//               buffers, handing over to the display side one full line at a time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module buffer_writer #(
    parameter int PX_PER_BUF = 640
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CSHost,
    input  logic [7:0] HostData,
    input  logic       HostValid,
    output logic       HostReady,
    input  logic       Buf0Empty,
    input  logic       Buf1Empty,
    output logic       WE0,
    output logic       WE1,
    output logic       SelR,
    output logic       SelG,
    output logic       SelB,
    output logic [7:0] WrData,
    output logic       IncAddr0,
    output logic       ResetAddr0,
    output logic       IncAddr1,
    output logic       ResetAddr1,
    output logic       Buf0Full,
    output logic       Buf1Full,
    output logic [9:0] WrPx
);

    localparam logic [9:0] C_LAST_PX = 10'(PX_PER_BUF - 1);
    localparam logic [1:0] C_PH_R    = 2'd0;
    localparam logic [1:0] C_PH_G    = 2'd1;
    localparam logic [1:0] C_PH_B    = 2'd2;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WRITE    = 3'd2,
        S_WAIT_BUF = 3'd3,
        S_SWITCH   = 3'd4
    } state_t;

    state_t     r_state,  w_state_n;
    logic       r_target, w_target_n;
    logic [1:0] r_phase,  w_phase_n;
    logic [9:0] r_px,     w_px_n;
    logic [1:0] r_full,   w_full_n;
    logic [1:0] r_we,     w_we_n;
    logic [2:0] r_sel,    w_sel_n;
    logic [7:0] r_data,   w_data_n;
    logic [1:0] r_inc,    w_inc_n;
    logic [1:0] r_rsta,   w_rsta_n;

    logic w_xfer;
    logic w_last;

    assign HostReady = (r_state == S_WRITE) && CSHost;
    assign w_xfer    = HostReady && HostValid;
    assign w_last    = w_xfer && (r_phase == C_PH_B) && (r_px == C_LAST_PX);

    always_comb begin
        w_state_n  = r_state;
        w_target_n = r_target;
        w_phase_n  = r_phase;
        w_px_n     = r_px;
        w_we_n     = 2'b00;
        w_sel_n    = 3'b000;
        w_data_n   = r_data;
        w_inc_n    = 2'b00;
        w_rsta_n   = 2'b00;

        case (r_state)
            S_INIT: w_state_n = S_IDLE;
            S_IDLE: begin
                if (CSHost)
                    w_state_n = r_full[r_target] ? S_WAIT_BUF : S_WRITE;
            end
            S_WRITE: begin
                if (!CSHost) begin
                    w_state_n = S_IDLE;
                end else if (w_xfer) begin
                    w_we_n[r_target] = 1'b1;
                    w_data_n         = HostData;
                    case (r_phase)
                        C_PH_R:  w_sel_n = 3'b100;
                        C_PH_G:  w_sel_n = 3'b010;
                        default: w_sel_n = 3'b001;
                    endcase
                    if (r_phase == C_PH_B) begin
                        w_phase_n         = C_PH_R;
                        w_inc_n[r_target] = 1'b1;
                        if (w_last) begin
                            w_px_n             = 10'd0;
                            w_rsta_n[r_target] = 1'b1;
                            w_state_n          = S_SWITCH;
                        end else begin
                            w_px_n = r_px + 10'd1;
                        end
                    end else begin
                        w_phase_n = r_phase + 2'd1;
                    end
                end
            end
            S_WAIT_BUF: begin
                if (!r_full[r_target])
                    w_state_n = S_WRITE;
            end
            S_SWITCH: begin
                w_target_n = ~r_target;
                w_state_n  = r_full[~r_target] ? S_WAIT_BUF : S_WRITE;
            end
            default: w_state_n = S_INIT;
        endcase
    end

    // A line completing on the same edge as a drain pulse keeps the flag set.
    always_comb begin
        w_full_n = r_full;
        if (w_last && !r_target)  w_full_n[0] = 1'b1;
        else if (Buf0Empty)       w_full_n[0] = 1'b0;
        if (w_last && r_target)   w_full_n[1] = 1'b1;
        else if (Buf1Empty)       w_full_n[1] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_target <= 1'b0;
            r_phase  <= C_PH_R;
            r_px     <= 10'd0;
            r_full   <= 2'b00;
            r_we     <= 2'b00;
            r_sel    <= 3'b000;
            r_data   <= 8'h00;
            r_inc    <= 2'b00;
            r_rsta   <= 2'b11;
        end else begin
            r_state  <= w_state_n;
            r_target <= w_target_n;
            r_phase  <= w_phase_n;
            r_px     <= w_px_n;
            r_full   <= w_full_n;
            r_we     <= w_we_n;
            r_sel    <= w_sel_n;
            r_data   <= w_data_n;
            r_inc    <= w_inc_n;
            r_rsta   <= w_rsta_n;
        end
    end

    assign WE0        = r_we[0];
    assign WE1        = r_we[1];
    assign SelR       = r_sel[2];
    assign SelG       = r_sel[1];
    assign SelB       = r_sel[0];
    assign WrData     = r_data;
    assign IncAddr0   = r_inc[0];
    assign IncAddr1   = r_inc[1];
    assign ResetAddr0 = r_rsta[0];
    assign ResetAddr1 = r_rsta[1];
    assign Buf0Full   = r_full[0];
    assign Buf1Full   = r_full[1];
    assign WrPx       = r_px;

endmodule

`default_nettype wire

// File: tb/tb_buffer_writer.sv
//------------------------------------------------------------------------------
// Module      : tb_buffer_writer
// Description : Directed bench for buffer_writer with a 4-pixel line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_buffer_writer;

    logic       clk;
    logic       reset;
    logic       CSHost;
    logic [7:0] HostData;
    logic       HostValid;
    logic       HostReady;
    logic       Buf0Empty, Buf1Empty;
    logic       WE0, WE1, SelR, SelG, SelB;
    logic [7:0] WrData;
    logic       IncAddr0, ResetAddr0, IncAddr1, ResetAddr1;
    logic       Buf0Full, Buf1Full;
    logic [9:0] WrPx;

    int n_vec  = 0;
    int n_fail = 0;
    bit mon_en = 0;
    logic rdy_s;

    buffer_writer #(.PX_PER_BUF(4)) dut (
        .clk(clk), .reset(reset), .CSHost(CSHost), .HostData(HostData),
        .HostValid(HostValid), .HostReady(HostReady),
        .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty),
        .WE0(WE0), .WE1(WE1), .SelR(SelR), .SelG(SelG), .SelB(SelB),
        .WrData(WrData), .IncAddr0(IncAddr0), .ResetAddr0(ResetAddr0),
        .IncAddr1(IncAddr1), .ResetAddr1(ResetAddr1),
        .Buf0Full(Buf0Full), .Buf1Full(Buf1Full), .WrPx(WrPx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, cs, valid;
        logic [7:0] data;
        logic       e0, e1;
        logic       rdy;
        logic [1:0] we;
        logic [2:0] sel;
        logic [7:0] wd;
        logic [1:0] inc, ra, full;
        logic [9:0] px;
    } vec_t;

    function automatic vec_t v(logic rst, logic cs, logic valid, logic [7:0] data,
                               logic e0, logic e1, logic rdy, logic [1:0] we,
                               logic [2:0] sel, logic [7:0] wd, logic [1:0] inc,
                               logic [1:0] ra, logic [1:0] full, logic [9:0] px);
        return '{rst, cs, valid, data, e0, e1, rdy, we, sel, wd, inc, ra, full, px};
    endfunction

    function automatic logic [28:0] outs();
        return {WE1, WE0, SelR, SelG, SelB, WrData, IncAddr1, IncAddr0,
                ResetAddr1, ResetAddr0, Buf1Full, Buf0Full, WrPx};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic cs, input logic valid, input logic [7:0] data,
                       input logic e0, input logic e1);
        @(negedge clk);
        reset = 1'b0; CSHost = cs; HostValid = valid; HostData = data;
        Buf0Empty = e0; Buf1Empty = e1;
        #1 rdy_s = HostReady;
        @(posedge clk);
        #1;
    endtask

    // Write-strobe exclusivity and one-hot colour select, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if ((WE0 & WE1) !== 1'b0 ||
                ((WE0 | WE1) && ({2'b0, SelR} + {2'b0, SelG} + {2'b0, SelB}) !== 3'd1) ||
                (!(WE0 | WE1) && {SelR, SelG, SelB} !== 3'b000)) begin
                n_fail++;
                $display("FAIL invariant: we=%b%b sel=%b%b%b", WE1, WE0, SelR, SelG, SelB);
            end
        end
    end

    vec_t vecs[17];

    initial begin
        reset = 1'b1; CSHost = 1'b0; HostValid = 1'b0; HostData = 8'h00;
        Buf0Empty = 1'b0; Buf1Empty = 1'b0;

        //            rst cs vl data  e0 e1 rdy we     sel     wd     inc    ra     full   px
        vecs[0]  = v(1, 0, 0, 8'h00, 0, 0, 0, 2'b00, 3'b000, 8'h00, 2'b00, 2'b11, 2'b00, 10'd0);
        vecs[1]  = v(0, 1, 1, 8'h01, 0, 0, 0, 2'b00, 3'b000, 8'h00, 2'b00, 2'b00, 2'b00, 10'd0);
        vecs[2]  = v(0, 1, 1, 8'h01, 0, 0, 0, 2'b00, 3'b000, 8'h00, 2'b00, 2'b00, 2'b00, 10'd0);
        vecs[3]  = v(0, 1, 1, 8'h01, 0, 0, 1, 2'b01, 3'b100, 8'h01, 2'b00, 2'b00, 2'b00, 10'd0);
        vecs[4]  = v(0, 1, 1, 8'h02, 0, 0, 1, 2'b01, 3'b010, 8'h02, 2'b00, 2'b00, 2'b00, 10'd0);
        vecs[5]  = v(0, 1, 1, 8'h03, 0, 0, 1, 2'b01, 3'b001, 8'h03, 2'b01, 2'b00, 2'b00, 10'd1);
        vecs[6]  = v(0, 1, 1, 8'h04, 0, 0, 1, 2'b01, 3'b100, 8'h04, 2'b00, 2'b00, 2'b00, 10'd1);
        vecs[7]  = v(0, 1, 1, 8'h05, 0, 0, 1, 2'b01, 3'b010, 8'h05, 2'b00, 2'b00, 2'b00, 10'd1);
        vecs[8]  = v(0, 1, 1, 8'h06, 0, 0, 1, 2'b01, 3'b001, 8'h06, 2'b01, 2'b00, 2'b00, 10'd2);
        vecs[9]  = v(0, 1, 1, 8'h07, 0, 0, 1, 2'b01, 3'b100, 8'h07, 2'b00, 2'b00, 2'b00, 10'd2);
        vecs[10] = v(0, 1, 1, 8'h08, 0, 0, 1, 2'b01, 3'b010, 8'h08, 2'b00, 2'b00, 2'b00, 10'd2);
        vecs[11] = v(0, 1, 1, 8'h09, 0, 0, 1, 2'b01, 3'b001, 8'h09, 2'b01, 2'b00, 2'b00, 10'd3);
        vecs[12] = v(0, 1, 1, 8'h0A, 0, 0, 1, 2'b01, 3'b100, 8'h0A, 2'b00, 2'b00, 2'b00, 10'd3);
        vecs[13] = v(0, 1, 1, 8'h0B, 0, 0, 1, 2'b01, 3'b010, 8'h0B, 2'b00, 2'b00, 2'b00, 10'd3);
        vecs[14] = v(0, 1, 1, 8'h0C, 0, 0, 1, 2'b01, 3'b001, 8'h0C, 2'b01, 2'b01, 2'b01, 10'd0);
        vecs[15] = v(0, 1, 1, 8'h0D, 0, 0, 0, 2'b00, 3'b000, 8'h0C, 2'b00, 2'b00, 2'b01, 10'd0);
        vecs[16] = v(0, 1, 1, 8'h0D, 0, 0, 1, 2'b10, 3'b100, 8'h0D, 2'b00, 2'b00, 2'b01, 10'd0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; CSHost = vecs[i].cs; HostValid = vecs[i].valid;
            HostData = vecs[i].data; Buf0Empty = vecs[i].e0; Buf1Empty = vecs[i].e1;
            #1;
            chk($sformatf("vec%0d ready", i), {31'd0, HostReady}, {31'd0, vecs[i].rdy});
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            chk($sformatf("vec%0d outputs", i), {3'd0, outs()},
                {3'd0, vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].inc,
                 vecs[i].ra, vecs[i].full, vecs[i].px});
        end

        // Fill buffer 1; drain pulse on the completing edge must not clear it.
        for (int i = 0; i < 11; i++) begin
            cyc(1, 1, 8'h0E + 8'(i), 0, (i == 10));
            chk("fill1 ready", {31'd0, rdy_s}, 32'd1);
        end
        chk("fill1 last", {3'd0, outs()},
            {3'd0, 2'b10, 3'b001, 8'h18, 2'b10, 2'b10, 2'b11, 10'd0});

        cyc(1, 1, 8'h19, 0, 0);
        chk("switch ready", {31'd0, rdy_s}, 32'd0);
        chk("switch strobes", {28'd0, WE1, WE0, ResetAddr1, ResetAddr0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 8'h19, 0, 0);
            chk("wait ready", {31'd0, rdy_s}, 32'd0);
            chk("wait state", {28'd0, WE1, WE0, Buf1Full, Buf0Full}, 32'b0011);
        end
        cyc(1, 1, 8'h19, 1, 0);
        chk("drain0 full", {30'd0, Buf1Full, Buf0Full}, 32'b10);
        cyc(1, 1, 8'h19, 0, 0);
        chk("resume gap ready", {31'd0, rdy_s}, 32'd0);
        chk("resume gap we", {30'd0, WE1, WE0}, 32'd0);
        cyc(1, 1, 8'h19, 0, 0);
        chk("resume ready", {31'd0, rdy_s}, 32'd1);
        chk("resume write", {3'd0, outs()},
            {3'd0, 2'b01, 3'b100, 8'h19, 2'b00, 2'b00, 2'b10, 10'd0});

        // Chip-select drop after a G byte; phase must survive the gap.
        cyc(1, 1, 8'h1A, 0, 0);
        chk("g byte sel", {29'd0, SelR, SelG, SelB}, 32'b010);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 8'h1B, (i == 2), 0);
            chk("cs low ready", {31'd0, rdy_s}, 32'd0);
            chk("cs low we", {30'd0, WE1, WE0}, 32'd0);
        end
        chk("empty ignored", {30'd0, Buf1Full, Buf0Full}, 32'b10);
        cyc(1, 1, 8'h1B, 0, 0);
        chk("cs idle ready", {31'd0, rdy_s}, 32'd0);
        cyc(1, 1, 8'h1B, 0, 0);
        chk("cs resume", {3'd0, outs()},
            {3'd0, 2'b01, 3'b001, 8'h1B, 2'b01, 2'b00, 2'b10, 10'd1});

        // Reset with buffer 1 full, then reset again mid-pixel.
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("reset1", {3'd0, outs()}, {3'd0, 2'b00, 3'b000, 8'h00, 2'b00, 2'b11, 2'b00, 10'd0});
        cyc(1, 1, 8'h31, 0, 0);
        cyc(1, 1, 8'h31, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 8'h31 + 8'(i), 0, 0);
            chk("pre-reset ready", {31'd0, rdy_s}, 32'd1);
        end
        chk("pre-reset px", {22'd0, WrPx}, 32'd2);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("reset2", {3'd0, outs()}, {3'd0, 2'b00, 3'b000, 8'h00, 2'b00, 2'b11, 2'b00, 10'd0});
        cyc(1, 1, 8'h55, 0, 0);
        chk("init ready", {31'd0, rdy_s}, 32'd0);
        chk("init exit ra", {30'd0, ResetAddr1, ResetAddr0}, 32'd0);
        cyc(1, 1, 8'h55, 0, 0);
        cyc(1, 1, 8'h55, 0, 0);
        chk("post-reset write", {3'd0, outs()},
            {3'd0, 2'b01, 3'b100, 8'h55, 2'b00, 2'b00, 2'b00, 10'd0});

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
